// File: rtl/car_request_detector.sv
// Car-present request conditioner: sync + debounce the loop sensor, hold the request until served.
// Latency: DEBOUNCE_CYCLES+2 edges sensor->car_req; no backpressure (free-running, outputs registered).
// Optional CAR_REQ_LATCH_EN: a raised request is held until served even if the car leaves.
module car_request_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       sensor_raw,
    input  logic [1:0] cntry_sig,
    output logic       car_req,
    output logic [7:0] served_count,
    output logic [1:0] req_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    logic       sync1, sync2, sensor_db;
    logic [7:0] db_cnt;
    logic [7:0] hold_cnt;
    state_t     state;
    logic       green;

    // Lamp code 3 (undriven) is deliberately not green.
    assign green = (cntry_sig == 2'd2);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sensor_db <= 1'b0;
            db_cnt    <= 8'd0;
        end else begin
            sync1 <= sensor_raw;
            sync2 <= sync1;
            if (sync2 == sensor_db) begin
                db_cnt <= 8'd0;
            end else if (db_cnt == DB_LAST) begin
                sensor_db <= sync2;
                db_cnt    <= 8'd0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state        <= IDLE;
            hold_cnt     <= 8'd0;
            served_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (sensor_db) state <= PENDING;
                end
                PENDING: begin
                    if (green) begin
                        state <= SERVING;
                        if (served_count != 8'hFF) served_count <= served_count + 8'd1;
                    end
`ifndef CAR_REQ_LATCH_EN
                    else if (!sensor_db) begin
                        state <= IDLE;
                    end
`endif
                end
                SERVING: begin
                    if (!sensor_db) begin
                        state    <= GAP;
                        hold_cnt <= HOLD_LOAD;
                    end else if (!green) begin
                        state <= PENDING;
                    end
                end
                GAP: begin
                    // A returning car during the gap is the same service, so no recount.
                    if (sensor_db) begin
                        state <= green ? SERVING : PENDING;
                    end else if (hold_cnt == 8'd0 || !green) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign car_req   = (state != IDLE);
    assign req_state = state;

endmodule

// File: doc/car_request_detector.md
# car_request_detector

Upstream stage of the highway/country-road signal controller. It conditions the raw country-road vehicle-loop sensor and produces the car-present request `X` that the controller consumes. The block synchronises and debounces the sensor, then holds the request until the controller actually serves it. It watches the controller's country-road lamp output as feedback, and counts the vehicles served.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples required to change the debounced sensor level (legal range 1–255).
- `HOLD_CYCLES`, default 8: gap time, in cycles, for which `car_req` is held after the sensor clears while the country road is green (legal range 1–255).

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `sensor_raw`  in  1  raw loop sensor; asynchronous to `clock`; may bounce.
- `cntry_sig`  in  2  country-road lamp from the controller; encoding RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
- `car_req`  out  1  registered request; drives the controller's `X`.
- `served_count`  out  8  saturating count of requests served.
- `req_state`  out  2  current FSM state, for debug.

## Operation
- **Reset** (`clear_n`=0, asynchronous):
  - Both synchroniser flops and `sensor_db` clear to 0.
  - Debounce counter and hold timer clear to 0.
  - State goes to IDLE (2'd0).
  - Outputs: `car_req`=0, `served_count`=0, `req_state`=0.
  - If reset is asserted mid-operation, a pending request is lost; nothing is retained.
- **Synchroniser:** two-flop chain `sensor_raw` → `sync1` → `sync2`.
- **Debounce:**
  - When `sync2`==`sensor_db`, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES`-1 and `sync2` still differs, `sensor_db` takes `sync2` and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` samples at `sync2` has no effect.
- **FSM states:** IDLE=0, PENDING=1, SERVING=2, GAP=3. `car_req`=1 in every state except IDLE.
- **FSM transitions:**
  - IDLE → PENDING when `sensor_db`=1.
  - PENDING → SERVING when `cntry_sig`==GREEN. On this transition `served_count` increments, saturating at 255. If `sensor_db`=1 and GREEN arrive in the same IDLE cycle, the FSM goes to PENDING only; SERVING follows on the next cycle.
  - SERVING → GAP when `sensor_db`=0; the hold timer loads `HOLD_CYCLES`-1.
  - SERVING → PENDING when `cntry_sig`!=GREEN and `sensor_db`=1 (controller timed out with a car still present; re-request).
  - GAP → SERVING when `sensor_db`=1 and `cntry_sig`==GREEN (car returned; no recount).
  - GAP → PENDING when `sensor_db`=1 and `cntry_sig`!=GREEN.
  - GAP → IDLE when `sensor_db`=0 and either the timer is 0 or `cntry_sig`!=GREEN. Otherwise the timer decrements by 1.
- **Undriven encoding:** `cntry_sig`=2'd3 is treated as not-GREEN.

## Timing
- **Rising latency:** `sensor_raw` rises and is stable before edge 0. `sync2`=1 after edge 1, `sensor_db`=1 after edge `DEBOUNCE_CYCLES`+1, and `car_req`=1 after edge `DEBOUNCE_CYCLES`+2. With default parameters that is edge 6.
- **Falling latency (IDLE path):** same pipeline depth, `DEBOUNCE_CYCLES`+2 edges.
- **Gap release:** the first GAP cycle is the edge after `sensor_db` falls. `car_req` deasserts exactly `HOLD_CYCLES` edges after entering GAP, with GREEN held throughout.
- **`served_count`:** updates on the same edge that `req_state` becomes SERVING.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`CAR_REQ_LATCH_EN` defined:** PENDING ignores `sensor_db`=0. Once raised, the request stays asserted until the country road has been served (latched demand).
- **`CAR_REQ_LATCH_EN` undefined:** PENDING → IDLE when `sensor_db`=0 and `cntry_sig`!=GREEN. `car_req` drops on that edge, so a car that leaves before being served cancels its request. If GREEN and `sensor_db`=0 occur in the same cycle, PENDING → SERVING takes priority.

## Test plan
Default parameters, 10 ns clock.

1. **Reset:** hold `clear_n`=0 for 3 cycles, then release → `car_req`=0, `served_count`=0, `req_state`=0. Assert `clear_n` low in PENDING → outputs go to 0 immediately, without waiting for a clock edge.
2. **Glitch rejection:** pulse `sensor_raw` high for 3 cycles → `sensor_db` and `car_req` stay 0. Hold it high instead → `car_req`=1 after edge 6.
3. **Served cycle:** request pending, then drive `cntry_sig`=2 → `req_state`=2 and `served_count`=1 on the same edge. Drop the sensor → `car_req` falls exactly 8 edges after GAP entry.
4. **Gap refill:** in GAP, re-assert the sensor (debounced) before the timer expires → state returns to SERVING, `car_req` stays 1 continuously, `served_count` is unchanged.
5. **Timeout and saturation:** in SERVING, set `cntry_sig`=0 with the car present → state goes to PENDING. Then drive 300 serve cycles → `served_count` holds at 255.
6. **Latch on/off:** with `CAR_REQ_LATCH_EN`, drop the sensor in PENDING → `car_req` stays 1. Without it → `car_req` goes to 0 on the edge after `sensor_db` falls.
